// File: rtl/byte_striping.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : byte_striping
// Description : Stripes a framed byte stream (STP/SDP ... END) across four
//               lanes, emitting one registered 4-byte group per full slot set.
// Revision    : 1.0 - initial release
// ============================================================================
module byte_striping #(
  parameter logic [7:0] COM = 8'hBC,
  parameter logic [7:0] PAD = 8'hF7,
  parameter logic [7:0] SKP = 8'h1C,
  parameter logic [7:0] STP = 8'hFB,
  parameter logic [7:0] SDP = 8'h5C,
  parameter logic [7:0] END = 8'hFD,
  parameter logic [7:0] EDB = 8'hFE,
  parameter logic [7:0] FTS = 8'h3C,
  parameter logic [7:0] IDL = 8'h7C
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] fromMux,
  input  logic       validIn,
  output logic [7:0] TL0,
  output logic [7:0] TL1,
  output logic [7:0] TL2,
  output logic [7:0] TL3,
  output logic       validOut,
  output logic       busy
);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_DATA = 1'b1
  } state_t;

  state_t     r_state;
  state_t     w_state_next;
  logic [1:0] r_idx;
  logic [1:0] w_idx_next;
  logic [7:0] r_buf [0:2];
  logic [7:0] w_group [0:3];
  logic       w_accept;
  logic       w_emit;
  logic       w_is_start;
  logic       w_is_end;

  // Remaining K-codes belong to the receive side and play no part in striping.
  logic [31:0] w_unused_kcodes;
  assign w_unused_kcodes = {COM, SKP, EDB, FTS};

  assign w_is_start = (fromMux == STP) || (fromMux == SDP);
  assign w_is_end   = (fromMux == END);
  assign busy       = (r_state == S_DATA);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_idx   <= 2'd0;
    end else begin
      r_state <= w_state_next;
      r_idx   <= w_idx_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_idx_next   = r_idx;
    w_accept     = 1'b0;
    w_emit       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (validIn && w_is_start) begin
          w_accept     = 1'b1;
          w_idx_next   = 2'd1;
          w_state_next = S_DATA;
        end
      end
      S_DATA: begin
        if (validIn) begin
          w_accept   = 1'b1;
          w_idx_next = r_idx + 2'd1;
          if (w_is_end) begin
            w_emit       = 1'b1;
            w_idx_next   = 2'd0;
            w_state_next = S_IDLE;
          end else if (r_idx == 2'd3) begin
            w_emit = 1'b1;
          end
        end
      end
      default: begin
        w_state_next = S_IDLE;
        w_idx_next   = 2'd0;
      end
    endcase
  end

  // Group assembly: held slots below idx, the incoming byte at idx, PAD above.
  // PAD only reaches the lanes when the incoming byte is END.
  for (genvar i = 0; i < 3; i++) begin : g_slot
    localparam logic [1:0] c_slot = 2'(i);
    assign w_group[i] = (c_slot < r_idx)  ? r_buf[i] :
                        (c_slot == r_idx) ? fromMux  : PAD;
  end
  assign w_group[3] = (r_idx == 2'd3) ? fromMux : PAD;

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 3; i++) r_buf[i] <= 8'h00;
      TL0      <= IDL;
      TL1      <= IDL;
      TL2      <= IDL;
      TL3      <= IDL;
      validOut <= 1'b0;
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (w_accept && (r_idx == 2'(i))) r_buf[i] <= fromMux;
      end
      if (w_emit) begin
        TL0      <= w_group[0];
        TL1      <= w_group[1];
        TL2      <= w_group[2];
        TL3      <= w_group[3];
        validOut <= 1'b1;
      end else begin
        TL0      <= IDL;
        TL1      <= IDL;
        TL2      <= IDL;
        TL3      <= IDL;
        validOut <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_byte_striping.sv
`default_nettype none
`timescale 1ns/1ps
// Scoreboard bench for byte_striping: expected lane groups are queued as
// stimulus is driven and popped whenever validOut is seen.
module tb_byte_striping;

  localparam logic [7:0] STP = 8'hFB;
  localparam logic [7:0] SDP = 8'h5C;
  localparam logic [7:0] END = 8'hFD;
  localparam logic [31:0] IDLE_LANES = 32'h7C7C7C7C;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] fromMux = 8'h00;
  logic       validIn = 1'b0;
  logic [7:0] TL0, TL1, TL2, TL3;
  logic       validOut;
  logic       busy;

  int tests = 0;
  int fails = 0;
  logic [31:0] exp_q [$];
  bit mon_en = 1'b0;

  always #5 clk = ~clk;

  byte_striping dut (
    .clk      (clk),
    .reset    (reset),
    .fromMux  (fromMux),
    .validIn  (validIn),
    .TL0      (TL0),
    .TL1      (TL1),
    .TL2      (TL2),
    .TL3      (TL3),
    .validOut (validOut),
    .busy     (busy)
  );

  // Lane monitor: every cycle either a queued group or all-IDL lanes.
  always @(posedge clk) begin
    #1;
    if (mon_en) begin
      tests++;
      if (validOut === 1'b1) begin
        if (exp_q.size() == 0) begin
          fails++;
          $display("FAIL unexpected_group: got %h expected no group", {TL0, TL1, TL2, TL3});
        end else begin
          logic [31:0] exp_g;
          exp_g = exp_q.pop_front();
          if ({TL0, TL1, TL2, TL3} !== exp_g) begin
            fails++;
            $display("FAIL group: got %h expected %h", {TL0, TL1, TL2, TL3}, exp_g);
          end
        end
      end else if (validOut !== 1'b0 || {TL0, TL1, TL2, TL3} !== IDLE_LANES) begin
        fails++;
        $display("FAIL idle_lanes: got %h valid %b expected %h valid 0",
                 {TL0, TL1, TL2, TL3}, validOut, IDLE_LANES);
      end
    end
  end

  task automatic drive(input logic [7:0] b, input logic v);
    @(negedge clk);
    fromMux = b;
    validIn = v;
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input string name);
    repeat (4) drive(8'h00, 1'b0);
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL %s_drain: got %0d groups outstanding expected 0", name, exp_q.size());
    end
    exp_q.delete();
  endtask

  task automatic test_reset();
    reset   = 1'b1;
    validIn = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    tests += 3;
    if ({TL0, TL1, TL2, TL3} !== IDLE_LANES) begin
      fails++;
      $display("FAIL reset_lanes: got %h expected %h", {TL0, TL1, TL2, TL3}, IDLE_LANES);
    end
    if (validOut !== 1'b0) begin
      fails++;
      $display("FAIL reset_valid: got %b expected 0", validOut);
    end
    if (busy !== 1'b0) begin
      fails++;
      $display("FAIL reset_busy: got %b expected 0", busy);
    end
    @(negedge clk);
    reset  = 1'b0;
    mon_en = 1'b1;
  endtask

  task automatic test_basic();
    exp_q.push_back(32'hFB1122FD);
    drive(STP, 1'b1);
    tests++;
    if (busy !== 1'b1) begin
      fails++;
      $display("FAIL basic_busy_rise: got %b expected 1", busy);
    end
    drive(8'h11, 1'b1);
    drive(8'h22, 1'b1);
    drive(END, 1'b1);
    tests++;
    if (busy !== 1'b0) begin
      fails++;
      $display("FAIL basic_busy_fall: got %b expected 0", busy);
    end
    drain("basic");
  endtask

  task automatic test_pad();
    exp_q.push_back(32'h5CA1A2A3);
    exp_q.push_back(32'hB1FDF7F7);
    drive(SDP, 1'b1);
    drive(8'hA1, 1'b1);
    drive(8'hA2, 1'b1);
    drive(8'hA3, 1'b1);
    drive(8'hB1, 1'b1);
    drive(END, 1'b1);
    drain("pad");
  endtask

  task automatic test_end_full();
    exp_q.push_back(32'hFB010203);
    exp_q.push_back(32'hFDF7F7F7);
    drive(STP, 1'b1);
    drive(8'h01, 1'b1);
    drive(8'h02, 1'b1);
    drive(8'h03, 1'b1);
    tests++;
    if (busy !== 1'b1) begin
      fails++;
      $display("FAIL end_full_busy_mid: got %b expected 1", busy);
    end
    drive(END, 1'b1);
    tests++;
    if (busy !== 1'b0) begin
      fails++;
      $display("FAIL end_full_busy_fall: got %b expected 0", busy);
    end
    drain("end_full");
  endtask

  task automatic test_gap();
    exp_q.push_back(32'hFB112233);
    exp_q.push_back(32'hFDF7F7F7);
    drive(STP, 1'b1);
    drive(8'h11, 1'b1);
    for (int i = 0; i < 3; i++) begin
      drive(8'hEE, 1'b0);
      tests++;
      if (busy !== 1'b1) begin
        fails++;
        $display("FAIL gap_busy: got %b expected 1", busy);
      end
    end
    drive(8'h22, 1'b1);
    drive(8'h33, 1'b1);
    drive(END, 1'b1);
    drain("gap");
  endtask

  task automatic test_idle_discard();
    logic [7:0] junk [3] = '{END, 8'h11, 8'h22};
    for (int i = 0; i < 3; i++) begin
      drive(junk[i], 1'b1);
      tests++;
      if (busy !== 1'b0) begin
        fails++;
        $display("FAIL idle_discard_busy: got %b expected 0", busy);
      end
    end
    drive(STP, 1'b0);
    tests++;
    if (busy !== 1'b0) begin
      fails++;
      $display("FAIL idle_invalid_start: got %b expected 0", busy);
    end
    drain("idle_discard");
  endtask

  task automatic test_nested();
    exp_q.push_back(32'hFB5C11FD);
    drive(STP, 1'b1);
    drive(SDP, 1'b1);
    drive(8'h11, 1'b1);
    drive(END, 1'b1);
    drain("nested");
  endtask

  task automatic test_back_to_back();
    exp_q.push_back(32'hFBAAFDF7);
    exp_q.push_back(32'h5CBBCCDD);
    exp_q.push_back(32'hFDF7F7F7);
    drive(STP, 1'b1);
    drive(8'hAA, 1'b1);
    drive(END, 1'b1);
    drive(SDP, 1'b1);
    tests++;
    if (busy !== 1'b1) begin
      fails++;
      $display("FAIL b2b_busy: got %b expected 1", busy);
    end
    drive(8'hBB, 1'b1);
    drive(8'hCC, 1'b1);
    drive(8'hDD, 1'b1);
    drive(END, 1'b1);
    drain("b2b");
  endtask

  task automatic test_reset_mid();
    drive(STP, 1'b1);
    drive(8'h11, 1'b1);
    @(negedge clk);
    reset   = 1'b1;
    fromMux = STP;
    validIn = 1'b1;
    @(posedge clk);
    #1;
    tests++;
    if (busy !== 1'b0) begin
      fails++;
      $display("FAIL reset_mid_busy: got %b expected 0", busy);
    end
    @(negedge clk);
    reset   = 1'b0;
    validIn = 1'b0;
    drive(8'h22, 1'b1);
    drive(END, 1'b1);
    tests++;
    if (busy !== 1'b0) begin
      fails++;
      $display("FAIL reset_mid_after: got %b expected 0", busy);
    end
    drain("reset_mid");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_pad();
    test_end_full();
    test_gap();
    test_idle_discard();
    test_nested();
    test_back_to_back();
    test_reset_mid();
    mon_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
